// File: rtl/instruction_queue_pkg.sv
// Shared cpu constants used by the instruction fetch path.
package instruction_queue_pkg;
    localparam int                  IQ_DATA_W = 32;
    localparam logic [IQ_DATA_W-1:0] NOP_INSTR = '0;
endpackage

// File: rtl/instruction_queue.sv
// Instruction queue: circular buffer with optional empty-queue fall-through
// and a held copy of the last consumed word.
module instruction_queue
    import instruction_queue_pkg::*;
#(
    parameter int DATA_W = IQ_DATA_W,
    parameter int DEPTH  = 4,
    parameter int BYPASS = 1
) (
    input  logic                       i_Clk,
    input  logic                       i_Rst,
    input  logic                       i_Flush,
    input  logic                       i_Wr,
    input  logic [DATA_W-1:0]          i_Data,
    output logic                       o_Full,
    input  logic                       i_Rd,
    output logic                       o_Valid,
    output logic [DATA_W-1:0]          o_Instruction,
    output logic [$clog2(DEPTH):0]     o_Count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic BYP = (BYPASS != 0);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] last_q, last_d;

    logic empty, full, fall_thru, wr_acc, rd_acc, store, pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign fall_thru = BYP & i_Wr;

    assign o_Full  = full;
    assign o_Count = count_q;
    assign o_Valid = ~empty | fall_thru;

    always_comb begin
        o_Instruction = last_q;
        if (!empty)
            o_Instruction = mem_q[rd_ptr_q];
        else if (fall_thru)
            o_Instruction = i_Data;
    end

    assign wr_acc = i_Wr & ~full;
    assign rd_acc = i_Rd & o_Valid;
    // A write consumed by fall-through never touches the array.
    assign store  = wr_acc & ~(empty & fall_thru & i_Rd);
    assign pop    = rd_acc & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        last_d   = last_q;
        if (i_Flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (store) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
            if (rd_acc) last_d  = o_Instruction;
            count_d = count_q + CW'(store) - CW'(pop);
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= DATA_W'(NOP_INSTR);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
        end
    end

    // Storage is not reset; the count alone decides what is live.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst && !i_Flush && store)
            mem_q[wr_ptr_q] <= i_Data;
    end
endmodule

// File: tb/tb_instruction_queue.sv
// Randomised and directed checks of instruction_queue against a queue-based model.
module tb_instruction_queue;
    localparam int DW = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst, flush, wr, rd;
    logic [DW-1:0] data;
    logic          full, valid;
    logic [DW-1:0] instr;
    logic [2:0]    count;

    logic          wr2, rd2;
    logic [DW-1:0] data2;
    logic          full2, valid2;
    logic [DW-1:0] instr2;
    logic [2:0]    count2;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_last;
    bit            chk_en = 0;

    always #5 clk = ~clk;

    instruction_queue #(.DATA_W(DW), .DEPTH(DEPTH), .BYPASS(1)) dut (
        .i_Clk(clk), .i_Rst(rst), .i_Flush(flush), .i_Wr(wr), .i_Data(data),
        .o_Full(full), .i_Rd(rd), .o_Valid(valid), .o_Instruction(instr), .o_Count(count));

    instruction_queue #(.DATA_W(DW), .DEPTH(DEPTH), .BYPASS(0)) dut_nb (
        .i_Clk(clk), .i_Rst(rst), .i_Flush(1'b0), .i_Wr(wr2), .i_Data(data2),
        .o_Full(full2), .i_Rd(rd2), .o_Valid(valid2), .o_Instruction(instr2), .o_Count(count2));

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, check combinational outputs before the edge, then advance the model.
    task automatic step(input logic r, input logic f, input logic w, input logic [DW-1:0] d,
                        input logic rdi);
        logic          m_valid;
        logic [DW-1:0] m_instr;
        bit            was_empty;
        @(negedge clk);
        rst = r; flush = f; wr = w; data = d; rd = rdi;
        #1;
        was_empty = (mq.size() == 0);
        m_valid = !was_empty || w;
        m_instr = !was_empty ? mq[0] : (w ? d : m_last);
        if (chk_en) begin
            chk("valid", DW'(valid), DW'(m_valid));
            chk("instr", instr, m_instr);
            chk("count", DW'(count), DW'(mq.size()));
            chk("full",  DW'(full),  DW'(mq.size() == DEPTH));
        end
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_last = '0;
        end else if (f) begin
            mq.delete();
        end else begin
            bit wr_ok;
            wr_ok = w && (mq.size() < DEPTH);
            if (rdi && m_valid) begin
                m_last = m_instr;
                if (!was_empty) void'(mq.pop_front());
            end
            if (wr_ok && !(was_empty && rdi)) mq.push_back(d);
        end
        chk_en = 1;
    endtask

    task automatic idle();
        step(0, 0, 0, '0, 0);
    endtask

    initial begin
        rst = 1; flush = 0; wr = 0; rd = 0; data = '0;
        wr2 = 0; rd2 = 0; data2 = '0;
        m_last = 'x;
        step(1, 0, 0, '0, 0);
        step(1, 0, 0, '0, 0);

        // Reset state, then fall-through of 0x13 with zero latency.
        @(negedge clk); rst = 0; wr = 1; data = 32'h13; rd = 1; #1;
        chk("rst_count", DW'(count), 0);
        chk("byp_valid", DW'(valid), 1);
        chk("byp_instr", instr, 32'h13);
        step(0, 0, 1, 32'h13, 1);
        @(negedge clk); wr = 0; rd = 0; #1;
        chk("byp_hold_instr", instr, 32'h13);
        chk("byp_hold_valid", DW'(valid), 0);
        chk("byp_hold_count", DW'(count), 0);

        // Fill to full, fifth write ignored, drain in order.
        step(0, 0, 1, 32'h11, 0);
        step(0, 0, 1, 32'h22, 0);
        step(0, 0, 1, 32'h33, 0);
        step(0, 0, 1, 32'h44, 0);
        @(negedge clk); wr = 0; #1;
        chk("full_flag", DW'(full), 1);
        chk("full_count", DW'(count), 4);
        step(0, 0, 1, 32'h55, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); wr = 0; rd = 0; #1;
            chk("drain_order", instr, 32'h11 * (i + 1));
            step(0, 0, 0, '0, 1);
        end
        idle();

        // Two entries, concurrent read+write across pointer wrap.
        step(0, 0, 1, 32'hA0, 0);
        step(0, 0, 1, 32'hA1, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 1, $urandom, 1);
        @(negedge clk); wr = 0; rd = 0; #1;
        chk("wrap_count", DW'(count), 2);
        idle();

        // Flush with three entries and a same-cycle write.
        step(0, 0, 1, 32'h1, 0);
        step(0, 0, 1, 32'h2, 0);
        step(0, 0, 1, 32'h3, 0);
        step(0, 1, 1, 32'hAA, 0);
        @(negedge clk); wr = 0; #1;
        chk("flush_count", DW'(count), 0);
        chk("flush_valid", DW'(valid), 0);
        chk("flush_instr", instr, m_last);
        idle();

        // Reset while full with a write pending.
        for (int i = 0; i < 4; i++) step(0, 0, 1, $urandom, 0);
        step(1, 0, 1, 32'hDEAD, 0);
        @(negedge clk); rst = 0; wr = 0; #1;
        chk("rstfull_count", DW'(count), 0);
        chk("rstfull_full", DW'(full), 0);
        chk("rstfull_instr", instr, 0);

        // Non-bypass instance: write is not visible until the next cycle.
        @(negedge clk); wr2 = 1; data2 = 32'h5; #1;
        chk("nb_valid0", DW'(valid2), 0);
        @(negedge clk); wr2 = 0; #1;
        chk("nb_valid1", DW'(valid2), 1);
        chk("nb_instr1", instr2, 32'h5);
        chk("nb_count1", DW'(count2), 1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 39) == 0),
                 $urandom_range(0, 1), $urandom, $urandom_range(0, 1));
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/instruction_queue.md
INSTRUCTION_QUEUE -- requirements
Module: instruction_queue

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, instruction word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, queue entries; a power of two, 2..16.
REQ-003 The block SHALL have parameter BYPASS, default 1; 1 enables fall-through from i_Data when empty, 0 disables it.
REQ-004 The block SHALL have port i_Clk, input, 1, rising-edge clock.
REQ-005 The block SHALL have port i_Rst, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port i_Flush, input, 1, discards all queued entries.
REQ-007 The block SHALL have port i_Wr, input, 1, write-valid for i_Data.
REQ-008 The block SHALL have port i_Data, input, DATA_W, fetched instruction word.
REQ-009 The block SHALL have port o_Full, output, 1, no free entry; a write is ignored while high.
REQ-010 The block SHALL have port i_Rd, input, 1, consumer accepts o_Instruction this cycle.
REQ-011 The block SHALL have port o_Valid, output, 1, o_Instruction holds a live entry.
REQ-012 The block SHALL have port o_Instruction, output, DATA_W, head entry, bypassed input, or held last word.
REQ-013 The block SHALL have port o_Count, output, $clog2(DEPTH)+1, number of stored entries.

Function
REQ-014 The block SHALL store entries in a circular buffer with write and read pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-015 The block SHALL perform an accepted write (i_Wr & ~o_Full) as a store at the write pointer on the next rising edge, unless that write is consumed by bypass (REQ-019).
REQ-016 The block SHALL perform an accepted read (i_Rd & o_Valid) as a write-pointer-independent advance of the read pointer on the next rising edge.
REQ-017 The block SHALL drive o_Valid = (o_Count != 0) | (BYPASS & i_Wr), combinationally.
REQ-018 The block SHALL drive o_Instruction as follows: the head entry when o_Count != 0; else i_Data when BYPASS=1 and i_Wr=1; else r_Last.
REQ-019 The block SHALL, when empty with BYPASS=1 and i_Wr=1 and i_Rd=1 in the same cycle, not store the word, leave o_Count at 0, and load i_Data into r_Last; zero added latency.
REQ-020 The block SHALL update r_Last to the delivered word on every accepted read, so that o_Instruction holds the last consumed word while empty, with o_Valid=0.
REQ-021 The block SHALL, on a simultaneous accepted read and accepted write when not empty, leave o_Count unchanged, with both pointers advancing.
REQ-022 The block SHALL, when full, allow a simultaneous i_Rd & i_Wr to ignore the write; o_Full is a registered-state function only, with no read-to-write combinational path.
REQ-023 The block SHALL drive o_Full = (o_Count == DEPTH).
REQ-024 The block SHALL give i_Flush priority over i_Wr and i_Rd: next cycle both pointers are 0, o_Count is 0, r_Last is unchanged, and a same-cycle write or read is discarded.
REQ-025 The block SHALL leave reads with o_Valid=0 and writes with o_Full=1 without effect on any state.
REQ-026 The block SHALL make storage latency 1 cycle: a word written at edge N is at the head by edge N if empty, visible in the cycle after N.

Reset
REQ-027 The block SHALL act on i_Rst only at a rising edge of i_Clk, and i_Rst SHALL have priority over i_Flush, i_Wr and i_Rd.
REQ-028 The block SHALL, after reset, have pointers=0, o_Count=0, r_Last=0, o_Valid=0, o_Full=0, and o_Instruction=0 (with i_Wr low).
REQ-029 The block SHALL, on reset mid-operation, discard all entries; storage array contents need not be cleared.

Structure
REQ-030 The design SHALL place in the shared cpu package: the DATA_W default constant and the NOP/reset instruction constant 0.
REQ-031 The design SHALL be implemented as a single module with no sub-module; the storage array is an inferred register/LUT-RAM of DEPTH x DATA_W.

Verification
REQ-032 The bench SHALL cover: reset, then i_Wr=1, i_Data=0x00000013, i_Rd=1 (BYPASS=1) -> same cycle o_Valid=1, o_Instruction=0x13; next cycle o_Count=0, o_Instruction=0x13 held, o_Valid=0.
REQ-033 The bench SHALL cover: write 0x11,0x22,0x33,0x44 with no reads (DEPTH=4) -> o_Count=4, o_Full=1; fifth write 0x55 ignored; reads return 0x11,0x22,0x33,0x44 in order.
REQ-034 The bench SHALL cover: with 2 entries, simultaneous read+write for 10 cycles across pointer wrap -> o_Count stays 2, order preserved.
REQ-035 The bench SHALL cover: with 3 entries, i_Flush=1 with i_Wr=1, i_Data=0xAA -> next cycle o_Count=0, o_Valid=0, 0xAA not stored, o_Instruction = last consumed word.
REQ-036 The bench SHALL cover: i_Rst=1 while full with i_Wr=1 -> next cycle o_Count=0, o_Full=0, o_Instruction=0.
REQ-037 The bench SHALL cover: with BYPASS=0, empty, i_Wr=1, i_Data=0x5 -> o_Valid=0 that cycle; next cycle o_Valid=1, o_Instruction=0x5.
